div_ctrl: RTL and testbench

Multi-cycle divide sequencer for DIV/DIVU in the Execute stage. Accepts operands from the E-stage forwarding muxes, runs a 32-iteration restoring divide, and holds the pipeline stalled until done. It then presents {remainder, quotient} as a 64-bit word for the HI/LO register write path. A flush cancels it cleanly.

---
 rtl/div_ctrl_pkg.sv | 14 +
 rtl/div_step.sv | 22 ++
 rtl/div_ctrl.sv | 110 +++++++++++
 tb/tb_div_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the E-stage divide sequencer: FSM encoding, iteration
// count and the DIV/DIVU funct codes the decoder uses to raise start/signed_div.
package div_ctrl_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int DIV_ITER = 32;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-divide iteration on magnitudes.
module div_step #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_rem,
    input  logic [DW-1:0] i_quo,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_rem,
    output logic [DW-1:0] o_quo
);

    logic [DW:0] w_shift;
    logic [DW:0] w_diff;

    // rem < divisor on entry, so the shifted value fits in DW+1 bits and a
    // failed trial leaves a value that fits back into DW bits.
    assign w_shift = {i_rem, i_quo[DW-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_rem   = w_diff[DW] ? w_shift[DW-1:0] : w_diff[DW-1:0];
    assign o_quo   = {i_quo[DW-2:0], ~w_diff[DW]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: stalls the pipeline while a restoring divide
// runs, then pulses done with {remainder, quotient} for the HI/LO write path.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DW = DIV_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_div,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] result
);

    localparam int CW = $clog2(DW) + 1;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_divisor;
    logic            r_quo_neg;
    logic            r_rem_neg;
    logic [2*DW-1:0] r_result;

    logic [DW-1:0]   w_rem_next;
    logic [DW-1:0]   w_quo_next;
    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW-1:0]   w_rem_fix;
    logic [DW-1:0]   w_quo_fix;
    logic            w_accept;
    logic            w_last;

    div_step #(.DW(DW)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_quo     (w_quo_next)
    );

    assign w_accept  = (r_state == S_IDLE) && start && !cancel;
    assign w_last    = (r_state == S_CALC) && (r_cnt == CW'(DW - 1));
    assign w_abs_a   = (signed_div && a[DW-1]) ? -a : a;
    assign w_abs_b   = (signed_div && b[DW-1]) ? -b : b;
    // Plain two's-complement negation: the most-negative / -1 case wraps back
    // to the most-negative value without any special handling.
    assign w_quo_fix = r_quo_neg ? -w_quo_next : w_quo_next;
    assign w_rem_fix = r_rem_neg ? -w_rem_next : w_rem_next;

    assign busy   = w_accept || (r_state == S_CALC);
    assign done   = (r_state == S_DONE) && !cancel;
    assign result = r_result;

    always_comb begin
        w_state_next = r_state;
        if (cancel) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_next = (b == '0) ? S_DONE : S_CALC;
                S_CALC:  if (w_last) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_quo_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (b != '0) begin
                    r_rem     <= '0;
                    r_quo     <= w_abs_a;
                    r_divisor <= w_abs_b;
                    r_quo_neg <= signed_div && (a[DW-1] ^ b[DW-1]);
                    r_rem_neg <= signed_div && a[DW-1];
                    r_cnt     <= '0;
                end else begin
                    r_result <= {a, {DW{1'b1}}};
                end
            end else if (r_state == S_CALC && !cancel) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= {w_rem_fix, w_quo_fix};
                end
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a vector table of single divides plus
// hand-written sequences for held start, cancel and asynchronous reset.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    div_ctrl #(.DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Start one divide in cycle 0 and observe a fixed 40-cycle window.
    task automatic run_op(input logic sd, input logic [31:0] a_i, input logic [31:0] b_i,
                          output logic [63:0] res, output int done_cyc, output int busy_cnt,
                          output int done_cnt, output logic busy_at_done);
        res = '0;
        done_cyc = -1;
        busy_cnt = 0;
        done_cnt = 0;
        busy_at_done = 1'bx;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sd; a = a_i; b = b_i;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0; a = $urandom; b = $urandom; signed_div = $urandom_range(0, 1);
            end
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res = result;
                    busy_at_done = busy;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] res;
        int          dcyc;
        int          bcnt;
        int          dcnt;
        logic        bdone;
        int          exp_lat;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        {32'h00000001, 32'h7FFFFFFC}};
        vecs[3] = '{1'b0, 32'h12345678,   32'd0,        {32'h12345678, 32'hFFFFFFFF}};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
        vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
        vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF}};
        vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'd0,        {32'hFFFFFFF9, 32'hFFFFFFFF}};
        vecs[9] = '{1'b0, 32'd5,          32'd2,        {32'h00000001, 32'h00000002}};

        rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy",   {63'd0, busy}, 64'd0);
        chk("reset_done",   {63'd0, done}, 64'd0);
        chk("reset_result", result,        64'd0);
        #10 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sd, vecs[i].a, vecs[i].b, res, dcyc, bcnt, dcnt, bdone);
            exp_lat = (vecs[i].b == 32'd0) ? 1 : 33;
            $display("vec %0d sd=%0d a=%h b=%h result=%h done_cycle=%0d busy_cycles=%0d",
                     i, vecs[i].sd, vecs[i].a, vecs[i].b, res, dcyc, bcnt);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp);
            chk($sformatf("v%0d_done_cycle", i), 64'(dcyc), 64'(exp_lat));
            chk($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(exp_lat));
            chk($sformatf("v%0d_done_pulses", i), 64'(dcnt), 64'd1);
            chk($sformatf("v%0d_busy_at_done", i), {63'd0, bdone}, 64'd0);
        end

        // start held high through DONE: one done, then re-accepted in cycle 34
        dcnt = 0; dcyc = -1; res = '0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b1; a = 32'h80000000; b = 32'hFFFFFFFF;
        for (int c = 0; c <= 34; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 34) begin signed_div = 1'b0; a = 32'd5; b = 32'd2; end
            @(negedge clk);
            if (c < 34 && done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = c; res = result; end
            end
            if (c == 34) begin
                chk("held_busy_c34", {63'd0, busy}, 64'd1);
                chk("held_done_c34", {63'd0, done}, 64'd0);
            end
        end
        $display("held_start result=%h done_cycle=%0d done_pulses=%0d", res, dcyc, dcnt);
        chk("held_result", res, {32'h0, 32'h80000000});
        chk("held_done_cycle", 64'(dcyc), 64'd33);
        chk("held_done_pulses", 64'(dcnt), 64'd1);
        dcyc = -1; res = '0;
        for (int c = 35; c < 75; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (done && dcyc < 0) begin dcyc = c; res = result; end
        end
        $display("restart 5/2 result=%h done_cycle=%0d", res, dcyc);
        chk("restart_result", res, {32'd1, 32'd2});
        chk("restart_done_cycle", 64'(dcyc), 64'd67);

        // cancel in cycle 10 of a 100/7, then 5/2 started in cycle 12
        dcnt = 0; dcyc = -1; res = '0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            start = 1'b0; cancel = 1'b0;
            if (c == 0)  begin start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7; end
            if (c == 10) cancel = 1'b1;
            if (c == 12) begin start = 1'b1; signed_div = 1'b0; a = 32'd5; b = 32'd2; end
            @(negedge clk);
            if (c == 11) begin
                chk("cancel_busy_c11", {63'd0, busy}, 64'd0);
                chk("cancel_result_c11", result, {32'd1, 32'd2});
            end
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = c; res = result; end
            end
        end
        $display("cancel_then_5/2 result=%h done_cycle=%0d done_pulses=%0d", res, dcyc, dcnt);
        chk("cancel_done_cycle", 64'(dcyc), 64'd45);
        chk("cancel_result", res, {32'd1, 32'd2});
        chk("cancel_done_pulses", 64'(dcnt), 64'd1);

        // asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b0;
        #1;
        $display("async_reset busy=%0d done=%0d result=%h", busy, done, result);
        chk("areset_busy",   {63'd0, busy}, 64'd0);
        chk("areset_done",   {63'd0, done}, 64'd0);
        chk("areset_result", result,        64'd0);
        @(negedge clk);
        rst = 1'b1;

        // start and cancel together in IDLE: nothing happens
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        chk("startcancel_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        $display("start_and_cancel busy=%0d done=%0d", busy, done);
        chk("startcancel_busy_next", {63'd0, busy}, 64'd0);
        chk("startcancel_done_next", {63'd0, done}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
